// File: rtl/operand_sweep_checker.sv
// Operand sweep checker: drives every aa/bb combination, compares DUT against golden per vector.
// Optional macro STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module operand_sweep_checker #(
   parameter int WIDTH = 2,
   parameter int HOLD  = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     cc,
   input  logic [WIDTH-1:0]     exp_cc,
   output logic [WIDTH-1:0]     aa,
   output logic [WIDTH-1:0]     bb,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     err_count,
   output logic [2*WIDTH-1:0]   first_fail_idx
);

   localparam int IW = 2 * WIDTH;
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [IW-1:0]   idx;
   logic [HW-1:0]   hold_cnt;
   logic            sample;
   logic            mismatch;
   logic            last_vec;
   logic            stop;
   logic [IW:0]     err_inc;

   assign sample   = (state == DRIVE) && (hold_cnt == HW'(HOLD - 1));
   assign mismatch = (cc != exp_cc);
   assign last_vec = (idx == '1);
   assign err_inc  = (err_count == '1) ? err_count : err_count + 1'b1;

`ifdef STOP_ON_FAIL_EN
   assign stop = sample && (last_vec || mismatch);
`else
   assign stop = sample && last_vec;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = DRIVE;
         DRIVE:   if (stop)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      aa   = '0;
      bb   = '0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         DRIVE: begin
            aa   = idx[IW-1:WIDTH];
            bb   = idx[WIDTH-1:0];
            busy = 1'b1;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Results persist through IDLE and are only cleared by reset or a new start.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx            <= '0;
         hold_cnt       <= '0;
         err_count      <= '0;
         first_fail_idx <= '0;
         pass           <= 1'b0;
      end else if (state == IDLE && start) begin
         idx            <= '0;
         hold_cnt       <= '0;
         err_count      <= '0;
         first_fail_idx <= '0;
         pass           <= 1'b0;
      end else if (state == DRIVE) begin
         if (sample) begin
            hold_cnt <= '0;
            if (!last_vec) idx <= idx + 1'b1;
            if (mismatch) begin
               err_count <= err_inc;
               if (err_count == '0) first_fail_idx <= idx;
            end
            if (stop) pass <= !mismatch && (err_count == '0);
         end else begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_operand_sweep_checker.sv
// Bench for operand_sweep_checker: cycle-count model of the sweep plus directed scenarios.
// Expectations follow STOP_ON_FAIL_EN when that macro is defined for the build.
module tb_operand_sweep_checker;

   localparam int WIDTH = 2;
   localparam int HOLD  = 20;
   localparam int NVEC  = 16;
`ifdef STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] cc;
   logic [1:0] exp_cc;
   logic [1:0] aa;
   logic [1:0] bb;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_count;
   logic [3:0] first_fail_idx;

   int tests = 0;
   int fails = 0;
   int mode  = 0;
   bit check_en = 1'b0;

   int m_phase = 0;
   int m_n     = 0;
   int m_err   = 0;
   int m_first = 0;
   bit m_pass  = 1'b0;
   int m_k;
   bit m_f;

   operand_sweep_checker #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .start(start), .cc(cc), .exp_cc(exp_cc),
      .aa(aa), .bb(bb), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail_idx(first_fail_idx)
   );

   always #5 clk = ~clk;

   // Golden model is a 2-bit adder; the DUT-side response is faulted according to mode.
   always_comb begin
      exp_cc = aa + bb;
      case (mode)
         1:       cc = exp_cc ^ {1'b0, (aa == 2'd2 && bb == 2'd1)};
         2:       cc = 2'd0;
         default: cc = exp_cc;
      endcase
   end

   function automatic bit vec_fails(input int k, input int m);
      int a;
      int b;
      a = k / 4;
      b = k % 4;
      case (m)
         1:       return (a == 2 && b == 1);
         2:       return ((a + b) % 4) != 0;
         default: return 1'b0;
      endcase
   endfunction

   // Model tracks cycles since the accepted start; vector k finishes at cycle (k+1)*HOLD.
   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_n = 0; m_err = 0; m_first = 0; m_pass = 1'b0;
      end else begin
         case (m_phase)
            0: if (start) begin
                  m_phase = 1; m_n = 0; m_err = 0; m_first = 0; m_pass = 1'b0;
               end
            1: begin
                  m_n = m_n + 1;
                  if (m_n % HOLD == 0) begin
                     m_k = m_n / HOLD - 1;
                     m_f = vec_fails(m_k, mode);
                     if (m_f) begin
                        if (m_err == 0) m_first = m_k;
                        if (m_err < 31) m_err = m_err + 1;
                     end
                     if (m_k == NVEC - 1 || (STOP && m_f)) begin
                        m_phase = 2;
                        m_pass  = (m_err == 0);
                     end
                  end
               end
            default: m_phase = 0;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("aa",   aa,   (m_phase == 1) ? (m_n / HOLD) / 4 : 0);
         checkOutput("bb",   bb,   (m_phase == 1) ? (m_n / HOLD) % 4 : 0);
         checkOutput("busy", busy, m_phase == 1);
         checkOutput("done", done, m_phase == 2);
         checkOutput("pass", pass, m_pass);
         checkOutput("err_count", err_count, m_err);
         checkOutput("first_fail_idx", first_fail_idx, m_first);
      end
   end

   // Runs one sweep from IDLE and pins the done cycle and final results to literal values.
   task automatic applyStimulus(input int m, input bit extra, input int want_cyc,
                                input int want_err, input int want_first, input bit want_pass);
      int c;
      bit seen;
      mode = m;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 0;
      seen = 1'b0;
      while (!seen && c < 400) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            start = extra && (c == 49);
            @(negedge clk);
            start = 1'b0;
            c++;
         end
      end
      checkOutput("done_seen", seen, 1);
      checkOutput("done_cycle", c, want_cyc);
      checkOutput("final_err", err_count, want_err);
      checkOutput("final_first", first_fail_idx, want_first);
      checkOutput("final_pass", pass, want_pass);
      if (extra) start = 1'b1;
      @(negedge clk); start = 1'b0;
      checkOutput("idle_after_done", busy, 0);
      @(negedge clk);
      checkOutput("still_idle", busy, 0);
   endtask

   task automatic resetMidSweep();
      int highs;
      mode = 2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_aabb", {aa, bb}, 0);
      checkOutput("rst_err", err_count, 0);
      checkOutput("rst_first", first_fail_idx, 0);
      checkOutput("rst_pass", pass, 0);
      highs = 0;
      repeat (300) begin
         @(negedge clk);
         if (done !== 1'b0) highs++;
      end
      checkOutput("no_done_after_rst", highs, 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      check_en = 1'b1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_err", err_count, 0);
      checkOutput("reset_pass", pass, 0);
      rst = 1'b0;
      applyStimulus(0, 1'b0, 320, 0, 0, 1'b1);
      applyStimulus(1, 1'b0, STOP ? 200 : 320, 1, 9, 1'b0);
      applyStimulus(2, 1'b0, STOP ? 40 : 320, STOP ? 1 : 12, 1, 1'b0);
      resetMidSweep();
      applyStimulus(0, 1'b1, 320, 0, 0, 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/operand_sweep_checker.md
# operand_sweep_checker

Self-checking response block for the 2-bit operand pair DUTs. It owns the operand side, driving `aa` and `bb` through all 2^(2*WIDTH) combinations with `aa` as the outer loop and `bb` as the inner loop, each combination held for HOLD cycles. It receives the DUT result `cc` and the golden result `exp_cc`, compares them once per vector, and reports a mismatch count, the first failing vector and a pass flag. It sits between a DUT instance and a golden-model instance, so a sweep runs as synthesizable hardware instead of a hand-written stimulus list.

## Interface
- WIDTH, 2, operand and result width in bits
- HOLD, 20, cycles each vector is held, legal range ≥ 2
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a sweep; ignored unless IDLE
- cc  in  WIDTH  DUT response
- exp_cc  in  WIDTH  golden response for the current `aa`/`bb`
- aa  out  WIDTH  operand A (outer loop)
- bb  out  WIDTH  operand B (inner loop)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  last completed sweep had zero mismatches
- err_count  out  2*WIDTH+1  mismatches in current or last sweep, saturating
- first_fail_idx  out  2*WIDTH  index {aa,bb} of the first mismatch; valid when err_count ≠ 0

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE → DRIVE on start. On that transition: idx=0, hold_cnt=0, err_count=0, pass=0, first_fail_idx=0.
- In DRIVE:
  - aa = idx[2W-1:W], bb = idx[W-1:0].
  - hold_cnt counts 0..HOLD-1.
  - At the edge where hold_cnt==HOLD-1, compare cc against exp_cc.
    - On mismatch: err_count+1, saturating at all-ones.
    - On the first mismatch of the sweep only: first_fail_idx=idx.
  - At the same edge, idx+1 and hold_cnt=0.
- After the sample of idx = all-ones, go DRIVE → DONE; idx does not wrap into another vector.
- DONE: done=1, busy=0, pass=(err_count==0), aa=bb=0. Next edge → IDLE.
- err_count, first_fail_idx and pass hold their values through IDLE until the next start.
- start in DRIVE or DONE has no effect.
- rst in any state: next edge gives IDLE and all outputs at reset values. No done pulse is emitted.
- Reset values: aa=0, bb=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0.
- The comparison is 2-state equality of all WIDTH bits. cc is sampled only at the last hold cycle, so the DUT has HOLD-1 cycles to settle.

## Timing
- Edge E0 samples start=1 in IDLE. After E0: busy=1, aa=bb=0.
- Vector k is driven after edges E(k*HOLD) through E((k+1)*HOLD-1) and sampled at edge E((k+1)*HOLD).
- done is high for the single cycle after edge E(2^(2W)*HOLD). With the defaults that is E320.
- busy falls in the same cycle that done rises.
- pass and final err_count are valid in the done cycle.
- Earliest restart: start sampled at the edge ending the done cycle is ignored. start in the following IDLE cycle is accepted.

## Configuration
- STOP_ON_FAIL_EN
  - Defined: the first mismatch ends the sweep. The sampling edge moves DRIVE → DONE, so done pulses in the next cycle with err_count=1, first_fail_idx set and pass=0.
  - Undefined: the sweep always covers all 2^(2W) vectors and counts every mismatch.

## Test plan
- Loopback (cc = exp_cc), defaults, start at E0 → done only in the cycle after E320; pass=1; err_count=0; aa/bb visit 00/00, 00/01 … 11/11 in order, each for 20 cycles.
- cc = exp_cc ^ 1 only when aa=2, bb=1 → err_count=1, first_fail_idx=9, pass=0, done after E320.
- exp_cc = (aa+bb) mod 4, cc tied to 0 → err_count=12, first_fail_idx=1, pass=0.
- rst high for one edge at E100 mid-sweep → all outputs at reset values next cycle, no done. A new start then completes normally with pass=1.
- start pulsed at E50 and in the done cycle → no effect on idx, and done timing unchanged (cycle after E320).
- STOP_ON_FAIL_EN defined, cc tied to 0, exp=(aa+bb) mod 4 → sweep ends at sample edge E40; done in the cycle after E40; err_count=1; first_fail_idx=1.
